// File: rtl/conv_tile_sched.sv
// Tile scheduler: walks the (n, m, row, col) tiles of one convolution layer in a
// selectable loop order and launches conv_tile for each through a start/done handshake.
module conv_tile_sched #(
  parameter int AW = 32,
  parameter int Tn = 8,
  parameter int Tm = 8,
  parameter int Tr = 16,
  parameter int Tc = 8,
  parameter int K  = 3,
  parameter int S  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] cfg_n,
  input  logic [AW-1:0] cfg_m,
  input  logic [AW-1:0] cfg_r,
  input  logic [AW-1:0] cfg_c,
  input  logic          cfg_order,
  output logic          tile_start,
  input  logic          tile_done,
  output logic [AW-1:0] tile_base_n,
  output logic [AW-1:0] tile_base_m,
  output logic [AW-1:0] tile_base_row,
  output logic [AW-1:0] tile_base_col,
  output logic [AW-1:0] tile_n_len,
  output logic [AW-1:0] tile_m_len,
  output logic [AW-1:0] tile_row_len,
  output logic [AW-1:0] tile_col_len,
  output logic          tile_last,
  output logic [AW-1:0] tile_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int TRK = (Tr + S - K) / S;
  localparam int TCK = (Tc + S - K) / S;

  generate
    if (S < 1 || TRK < 1 || TCK < 1) begin : g_bad_params
      $error("conv_tile_sched: tile must hold at least one output row and column");
    end
  endgenerate

  localparam logic [AW-1:0] TN_W  = AW'(Tn);
  localparam logic [AW-1:0] TM_W  = AW'(Tm);
  localparam logic [AW-1:0] TRK_W = AW'(TRK);
  localparam logic [AW-1:0] TCK_W = AW'(TCK);
  localparam logic [AW-1:0] K_W   = AW'(K);
  localparam logic [AW-1:0] S_W   = AW'(S);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, ADV, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] n_q, m_q, rk_q, ck_q;
  logic          order_q, invalid_q;
  // Cursors: channel bases, and row/col offsets in output-pixel space.
  logic [AW-1:0] bn_q, bm_q, orow_q, ocol_q;
  logic [AW-1:0] base_n_q, base_m_q, base_row_q, base_col_q;
  logic [AW-1:0] n_len_q, m_len_q, row_len_q, col_len_q;
  logic [AW-1:0] tile_cnt_q;
  logic          tile_last_q;

  logic [AW-1:0] rem_n, rem_m, rem_r, rem_c;
  logic          last_n, last_m, last_r, last_c;
  logic          invalid_d;
  logic [AW-1:0] rk_d, ck_d;

  always_comb begin
    rem_n  = n_q - bn_q;
    rem_m  = m_q - bm_q;
    rem_r  = rk_q - orow_q;
    rem_c  = ck_q - ocol_q;
    last_n = (rem_n <= TN_W);
    last_m = (rem_m <= TM_W);
    last_r = (rem_r <= TRK_W);
    last_c = (rem_c <= TCK_W);
    invalid_d = (cfg_n == '0) || (cfg_m == '0) || (cfg_r == '0) || (cfg_c == '0) ||
                (cfg_r < K_W) || (cfg_c < K_W);
    rk_d = (cfg_r + S_W - K_W) / S_W;
    ck_d = (cfg_c + S_W - K_W) / S_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      m_q         <= '0;
      rk_q        <= '0;
      ck_q        <= '0;
      order_q     <= 1'b0;
      invalid_q   <= 1'b0;
      bn_q        <= '0;
      bm_q        <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      base_n_q    <= '0;
      base_m_q    <= '0;
      base_row_q  <= '0;
      base_col_q  <= '0;
      n_len_q     <= '0;
      m_len_q     <= '0;
      row_len_q   <= '0;
      col_len_q   <= '0;
      tile_cnt_q  <= '0;
      tile_last_q <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q        <= cfg_n;
            m_q        <= cfg_m;
            rk_q       <= rk_d;
            ck_q       <= ck_d;
            order_q    <= cfg_order;
            invalid_q  <= invalid_d;
            bn_q       <= '0;
            bm_q       <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            tile_cnt_q <= '0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (invalid_q) begin
            state_q <= DONE;
          end else begin
            base_n_q    <= bn_q;
            base_m_q    <= bm_q;
            base_row_q  <= orow_q * S_W;
            base_col_q  <= ocol_q * S_W;
            n_len_q     <= last_n ? rem_n : TN_W;
            m_len_q     <= last_m ? rem_m : TM_W;
            row_len_q   <= last_r ? rem_r : TRK_W;
            col_len_q   <= last_c ? rem_c : TCK_W;
            tile_last_q <= last_n && last_m && last_r && last_c;
            state_q     <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (tile_done) state_q <= tile_last_q ? DONE : ADV;
        end
        ADV: begin
          tile_cnt_q <= tile_cnt_q + 1'b1;
          state_q    <= CALC;
          if (!order_q) begin
            // col -> row -> m -> n
            if (!last_c) ocol_q <= ocol_q + TCK_W;
            else begin
              ocol_q <= '0;
              if (!last_r) orow_q <= orow_q + TRK_W;
              else begin
                orow_q <= '0;
                if (!last_m) bm_q <= bm_q + TM_W;
                else begin
                  bm_q <= '0;
                  bn_q <= bn_q + TN_W;
                end
              end
            end
          end else begin
            // m -> col -> row -> n
            if (!last_m) bm_q <= bm_q + TM_W;
            else begin
              bm_q <= '0;
              if (!last_c) ocol_q <= ocol_q + TCK_W;
              else begin
                ocol_q <= '0;
                if (!last_r) orow_q <= orow_q + TRK_W;
                else begin
                  orow_q <= '0;
                  bn_q   <= bn_q + TN_W;
                end
              end
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tile_start    = (state_q == ISSUE);
  assign done          = (state_q == DONE);
  assign err           = (state_q == DONE) && invalid_q;
  assign busy          = (state_q != IDLE);
  assign tile_base_n   = base_n_q;
  assign tile_base_m   = base_m_q;
  assign tile_base_row = base_row_q;
  assign tile_base_col = base_col_q;
  assign tile_n_len    = n_len_q;
  assign tile_m_len    = m_len_q;
  assign tile_row_len  = row_len_q;
  assign tile_col_len  = col_len_q;
  assign tile_last     = tile_last_q;
  assign tile_cnt      = tile_cnt_q;

endmodule

// File: doc/conv_tile_sched.md
# conv_tile_sched

Runtime-configurable tile scheduler for the convolution accelerator. It sits between the layer-level controller and `conv_tile`, and replaces the fixed-parameter tile-coordinate generator, tile counter and start-sequencing glue. Per layer it walks every (n, m, row, col) tile in one of two loop orders and hands `conv_tile` one tile at a time through a start/done handshake. For each tile it supplies base coordinates and clipped edge-tile lengths.

## Interface
- AW, 32, coordinate/count width
- Tn, 8, output channels per tile
- Tm, 8, input channels per tile
- Tr, 16, input rows per tile
- Tc, 8, input cols per tile
- K, 3, kernel size
- S, 1, stride
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  layer start pulse; sampled only in IDLE
- abort  in  1  cancel layer; return to IDLE
- cfg_n, cfg_m, cfg_r, cfg_c  in  AW each  layer N, M, R, C; latched on accepted start
- cfg_order  in  1  loop order: 0 = col→row→m→n (col innermost); 1 = m→col→row→n (m innermost)
- tile_start  out  1  one-cycle pulse that launches the current tile
- tile_done  in  1  tile-complete pulse from conv_tile
- tile_base_n, tile_base_m, tile_base_row, tile_base_col  out  AW each  tile origin (channel indices; row and col as input-FM coordinates)
- tile_n_len, tile_m_len  out  AW each  valid channels in the tile (≤Tn, ≤Tm)
- tile_row_len, tile_col_len  out  AW each  valid output rows/cols in the tile (≤TRK, ≤TCK)
- tile_last  out  1  current tile is the final tile of the layer
- tile_cnt  out  AW  index of the current tile, starting at 0
- busy  out  1  a layer is in progress
- done  out  1  one-cycle layer-complete pulse
- err  out  1  valid with done; configuration was rejected

## Operation
- Derived constants:
  - TRK = (Tr+S−K)/S; TCK = (Tc+S−K)/S. Both must be ≥1; enforce this at elaboration.
  - Latched RK = (cfg_r+S−K)/S; CK = (cfg_c+S−K)/S.
- Tile counts: ceil(cfg_n/Tn), ceil(cfg_m/Tm), ceil(RK/TRK), ceil(CK/TCK).
- Coordinates:
  - base_n = in·Tn; base_m = im·Tm.
  - base_row = ir·TRK·S; base_col = ic·TCK·S.
- Lengths:
  - n_len = min(Tn, cfg_n−base_n); m_len follows the same rule.
  - row_len = min(TRK, RK−ir·TRK); col_len = min(TCK, CK−ic·TCK).
- Arithmetic is unsigned, AW bits. Division is by constants only.
- Config is invalid if any cfg dim is 0, or cfg_r<K, or cfg_c<K.
- FSM states: IDLE, CALC, ISSUE, WAIT, ADV, DONE.
  - IDLE: start=1 latches cfg, clears indices and tile_cnt, and moves to CALC.
  - CALC: registers base/len/tile_last for the current indices. Moves to ISSUE, or to DONE with err=1 if the config is invalid.
  - ISSUE: tile_start=1 for exactly one cycle, then WAIT.
  - WAIT: on tile_done, go to DONE if tile_last, else to ADV.
  - ADV: increment the innermost index per cfg_order with carry into outer indices; tile_cnt+1; then CALC.
  - DONE: done=1 for one cycle, then IDLE.
- busy = 1 in every state except IDLE.
- abort in any non-IDLE state: IDLE on the next edge, with no done and no tile_start. Abort takes priority over tile_done in the same cycle.
- Ignored inputs:
  - start outside IDLE.
  - tile_done outside WAIT.
- cfg_* changes while busy have no effect.
- Tile outputs hold stable from CALC until the next CALC.

## Timing
- Reset values: tile_start=0, done=0, err=0, busy=0, tile_last=0, tile_cnt=0, and all base/len outputs 0. State = IDLE.
- All outputs are registered or decoded from state only; none is combinational from an input.
- Start latency: start sampled at edge 0 → CALC in cycle 1 → tile_start high in cycle 2, with coordinates already valid.
- Tile-to-tile: tile_done high in cycle t → ADV (t+1) → CALC (t+2) → tile_start (t+3).
- Last tile: tile_done in cycle t → done=1 in t+1 → IDLE in t+2. A new start is accepted in t+2.
- Invalid config: start at edge 0 → done=1 and err=1 in cycle 2; no tile_start is issued.
- A single-tile layer is legal: tile_last=1 on the first tile.
- rst asserted mid-layer: the next edge restores all reset values.

## Test plan
- Defaults with cfg 16/16/32/16, order 0:
  - Expect 36 tile_starts; done one cycle after the 36th tile_done.
  - row bases 0,14,28 with row_len 14,14,2; col bases 0,6,12 with col_len 6,6,2.
  - tile_cnt runs 0..35.
- Same config, order 1:
  - First three tiles are (n0,m0,r0,c0), (n0,m8,r0,c0), (n0,m0,r0,c6).
  - Total is 36; the set of tiles is identical to order 0.
- Channel edge case, cfg_n=12, cfg_m=5, R=C=3:
  - 2 tiles: n_len 8 then 4; m_len 5; row_len=col_len=1.
  - tile_last=1 on the second tile.
- Invalid config:
  - cfg_r=2 → done and err in cycle 2, no tile_start.
  - cfg_n=0 → same response.
- abort in WAIT of tile 5, asserted together with tile_done:
  - IDLE next cycle; busy=0; no done.
  - A following start begins again at tile_cnt=0.
- Spurious tile_done in IDLE/ISSUE and start while busy are both ignored.
- rst asserted mid-layer clears all outputs on the next edge.
